his_builder_fsm: RTL and testbench

Per-pixel time-of-flight histogram builder for the dToF pipeline. It accepts a stream of coarse timestamps, one per cycle, arriving pixel-interleaved. It accumulates a coarse histogram for each pixel over `ACQ_NUM` acquisitions, then scans the histograms and reports each pixel's peak bin as a timestamp. It sits between the TDC/timestamp front end and the fine-peak/depth stage.

---
 rtl/his_builder_fsm.sv | 121 ++++++++++++
 tb/tb_his_builder_fsm.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/his_builder_fsm.sv
// Per-pixel coarse ToF histogram builder: accumulates ACQ_NUM shots, then scans for each pixel's peak bin.
// Build option HIS_SATURATE_EN: bin counters saturate instead of wrapping.
module his_builder_fsm #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int ACQ_NUM           = 2,
    parameter int BIN_BITS          = 4,
    parameter int CNT_W             = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM],
    output logic          peakValid
);

    localparam int BINS = 2 ** BIN_BITS;
    localparam int PW   = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
    localparam int AW   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    localparam logic [PW-1:0]       PIX_LAST = PW'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [AW-1:0]       ACQ_LAST = AW'(ACQ_NUM - 1);
    localparam logic [BIN_BITS-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ACCUM,
        SEARCH,
        DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    hist_q     [PIXEL_NUM_PER_RAM][BINS];
    logic [PW-1:0]       pix_q;
    logic [AW-1:0]       acq_q;
    logic [BIN_BITS-1:0] idx_q;
    logic [BIN_BITS-1:0] best_bin_q [PIXEL_NUM_PER_RAM];
    logic [CNT_W-1:0]    best_cnt_q [PIXEL_NUM_PER_RAM];
    logic [NP-1:0]       peak_q     [PIXEL_NUM_PER_RAM];
    logic                valid_q;

    logic [BIN_BITS-1:0] bin_d;
    logic [CNT_W-1:0]    cur_cnt;
    logic [CNT_W-1:0]    inc_cnt;
    logic                unused_lsb;

    assign bin_d      = data[NP-1 -: BIN_BITS];
    assign unused_lsb = ^data[NP-BIN_BITS-1:0];
    assign cur_cnt    = hist_q[pix_q][bin_d];

`ifdef HIS_SATURATE_EN
    assign inc_cnt = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
`else
    assign inc_cnt = cur_cnt + CNT_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ACCUM;
            pix_q   <= '0;
            acq_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                best_bin_q[p] <= '0;
                best_cnt_q[p] <= '0;
                peak_q[p]     <= '0;
                for (int b = 0; b < BINS; b++) hist_q[p][b] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ACCUM: begin
                    if (wrEn) begin
                        hist_q[pix_q][bin_d] <= inc_cnt;
                        if (pix_q == PIX_LAST) begin
                            pix_q <= '0;
                            if (acq_q == ACQ_LAST) begin
                                acq_q   <= '0;
                                idx_q   <= '0;
                                state_q <= SEARCH;
                                for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                                    best_bin_q[p] <= '0;
                                    best_cnt_q[p] <= '0;
                                end
                            end else begin
                                acq_q <= acq_q + AW'(1);
                            end
                        end else begin
                            pix_q <= pix_q + PW'(1);
                        end
                    end
                end
                SEARCH: begin
                    // Strict compare: on a tie the earlier (lower) bin wins.
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        if (hist_q[p][idx_q] > best_cnt_q[p]) begin
                            best_cnt_q[p] <= hist_q[p][idx_q];
                            best_bin_q[p] <= idx_q;
                        end
                    end
                    idx_q <= idx_q + BIN_BITS'(1);
                    if (idx_q == IDX_LAST) state_q <= DONE;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    state_q <= ACCUM;
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        peak_q[p] <= {best_bin_q[p], {(NP - BIN_BITS){1'b0}}};
                        for (int b = 0; b < BINS; b++) hist_q[p][b] <= '0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign peakResult = peak_q;
    assign peakValid  = valid_q;

endmodule

// File: tb/tb_his_builder_fsm.sv
// Randomized bench for his_builder_fsm against a bin-count/argmax reference model.
// Two instances: default geometry, and a 1-pixel 300-shot one for counter overflow.
module tb_his_builder_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res;
    logic       wrEn_a, wrEn_b;
    logic [9:0] data_a, data_b;
    logic [9:0] pr_a [3];
    logic [9:0] pr_b [1];
    logic       pv_a, pv_b;

    int vectors = 0;
    int errors  = 0;

`ifdef HIS_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    his_builder_fsm dut_a (
        .clk(clk), .res(res), .wrEn(wrEn_a), .data(data_a),
        .peakResult(pr_a), .peakValid(pv_a)
    );

    his_builder_fsm #(.PIXEL_NUM_PER_RAM(1), .ACQ_NUM(300)) dut_b (
        .clk(clk), .res(res), .wrEn(wrEn_b), .data(data_b),
        .peakResult(pr_b), .peakValid(pv_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count samples per bin for pixel p, apply counter width, pick first maximum.
    function automatic int peak_of(input int q[$], input int np, input int p);
        int cnt[16];
        int best = 0;
        int bb   = 0;
        int c;
        foreach (cnt[b]) cnt[b] = 0;
        for (int i = 0; i < q.size(); i++)
            if (i % np == p) cnt[q[i] / 64]++;
        for (int b = 0; b < 16; b++) begin
            c = SAT ? ((cnt[b] > 255) ? 255 : cnt[b]) : (cnt[b] % 256);
            if (c > best) begin
                best = c;
                bb   = b;
            end
        end
        return bb * 64;
    endfunction

    task automatic send(input bit sel, input int d, input int gap);
        repeat (gap) begin
            if (sel) wrEn_b = 1'b0; else wrEn_a = 1'b0;
            @(negedge clk);
        end
        if (sel) begin
            wrEn_b = 1'b1;
            data_b = 10'(d);
        end else begin
            wrEn_a = 1'b1;
            data_a = 10'(d);
        end
        @(negedge clk);
    endtask

    task automatic await_peak(input bit sel, input bit junk, input string tag);
        int cyc = 1;
        while (cyc < 40) begin
            if ((sel ? pv_b : pv_a) === 1'b1) break;
            if (sel) begin
                wrEn_b = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                data_b = 10'($urandom_range(0, 1023));
            end else begin
                wrEn_a = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                data_a = 10'($urandom_range(0, 1023));
            end
            @(negedge clk);
            cyc++;
        end
        wrEn_a = 1'b0;
        wrEn_b = 1'b0;
        check({tag, "_latency"}, cyc - 1, 17);
        @(negedge clk);
        check({tag, "_pulse"}, sel ? pv_b : pv_a, 0);
    endtask

    task automatic run_frame_a(input int q[$], input bit gaps, input bit junk, input string tag);
        foreach (q[i]) send(1'b0, q[i], gaps ? $urandom_range(0, 3) : 0);
        await_peak(1'b0, junk, tag);
        for (int p = 0; p < 3; p++)
            check($sformatf("%s_p%0d", tag, p), pr_a[p], peak_of(q, 3, p));
    endtask

    task automatic run_frame_b(input int q[$], input int lit, input string tag);
        foreach (q[i]) send(1'b1, q[i], 0);
        await_peak(1'b1, 1'b0, tag);
        check({tag, "_model"}, pr_b[0], peak_of(q, 1, 0));
        check({tag, "_lit"}, pr_b[0], lit);
    endtask

    initial begin
        int q[$];
        int seen;
        res    = 1'b1;
        wrEn_a = 1'b0;
        wrEn_b = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        check("rst_valid", pv_a, 0);
        for (int p = 0; p < 3; p++) check($sformatf("rst_pr%0d", p), pr_a[p], 0);
        check("rst_valid_b", pv_b, 0);

        // Basic frame
        q = '{108, 511, 1022, 100, 500, 1000};
        run_frame_a(q, 1'b0, 1'b0, "basic");
        check("basic_lit0", pr_a[0], 64);
        check("basic_lit1", pr_a[1], 448);
        check("basic_lit2", pr_a[2], 960);

        // Tie-break: pixel 0 has one count in bins 1 and 4
        q = '{108, 700, 20, 300, 710, 900};
        run_frame_a(q, 1'b0, 1'b0, "tie");
        check("tie_lit0", pr_a[0], 64);

        // Same basic stream with idle gaps and junk during the busy window
        q = '{108, 511, 1022, 100, 500, 1000};
        run_frame_a(q, 1'b1, 1'b1, "gaps");
        check("gaps_lit1", pr_a[1], 448);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            q.delete();
            for (int i = 0; i < 6; i++)
                q.push_back((f % 2 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 255));
            run_frame_a(q, 1'(f % 2), 1'b1, $sformatf("rnd%0d", f));
        end

        // Reset in the middle of the search
        q = '{900, 901, 902, 903, 904, 905};
        foreach (q[i]) send(1'b0, q[i], 0);
        wrEn_a = 1'b0;
        repeat (4) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res  = 1'b0;
        seen = 0;
        repeat (30) begin
            if (pv_a === 1'b1) seen++;
            @(negedge clk);
        end
        check("midrst_novalid", seen, 0);
        for (int p = 0; p < 3; p++) check($sformatf("midrst_pr%0d", p), pr_a[p], 0);

        q = '{108, 511, 1022, 100, 500, 1000};
        run_frame_a(q, 1'b0, 1'b0, "postrst");

        // Counter overflow on the single-pixel instance
        q.delete();
        repeat (300) q.push_back(70);
        run_frame_b(q, 64, "ovf1");

        q.delete();
        repeat (260) q.insert($urandom_range(0, q.size()), $urandom_range(64, 127));
        repeat (40) q.insert($urandom_range(0, q.size()), $urandom_range(192, 255));
        run_frame_b(q, SAT ? 64 : 192, "ovf2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
